// File: rtl/nlx_sram_slave.sv
// nlx_sram_slave: word-addressed single-port SRAM target for the nlx_sram bus.
// It handles byte-enabled writes and returns reads after RD_LAT clock edges
// through a {valid, data} shift pipeline. It also flags out-of-range requests
// and keeps a saturating count of them.
module nlx_sram_slave #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs,
  input  logic [3:0]  we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        oor_err,
  output logic [15:0] oor_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_en;
  logic          oor_hit;

  // The full 16-bit address takes part in the range check, so upper bits
  // can never alias onto an implemented word.
  assign in_range = ({16'd0, addr} < DEPTH);
  assign idx      = addr[AW-1:0];
  assign wr_en    = rstn && cs && (we != 4'b0000) && in_range;
  assign oor_hit  = rstn && cs && !in_range;

  // Byte-enabled write port. Reset leaves the stored contents untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && we[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---- stage p0: request decode and word fetch at the request edge ----
  logic        vld_p0;
  logic [31:0] data_p0;
  assign vld_p0  = rstn && cs && (we == 4'b0000);
  assign data_p0 = in_range ? mem_q[idx] : OOR_DATA;

  logic        vld_last;
  logic [31:0] data_last;

  generate
    if (RD_LAT == 1) begin : g_direct
      assign vld_last  = vld_p0;
      assign data_last = data_p0;
    end else begin : g_pipe
      // ---- stages p1..p(RD_LAT-1): extra latency, one read per slot ----
      logic [RD_LAT-2:0] vld_pipe_q;
      logic [31:0]       data_pipe_q [RD_LAT-1];

      // Valid bits shift every cycle and are cleared by reset, so reads
      // still in flight are dropped.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[0] <= vld_p0;
          for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
          end
        end
      end

      // Data slots shift alongside their valid bits. They need no reset
      // because they are only used when their valid bit is set.
      always_ff @(posedge clk) begin
        data_pipe_q[0] <= data_p0;
        for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
          data_pipe_q[i] <= data_pipe_q[i-1];
        end
      end

      assign vld_last  = vld_pipe_q[RD_LAT-2];
      assign data_last = data_pipe_q[RD_LAT-2];
    end
  endgenerate

  // ---- output stage: registered rdata/rvalid ----
  logic [31:0] rdata_q;
  logic        rvalid_q;

  // rvalid is a one-cycle strobe per read. rdata changes only with a new
  // result and otherwise holds its last value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= vld_last;
      if (vld_last) begin
        rdata_q <= data_last;
      end
    end
  end

  logic        oor_err_q;
  logic [15:0] oor_cnt_q;
  logic [15:0] oor_cnt_d;

  // Next out-of-range count.
  always_comb begin
    oor_cnt_d = oor_cnt_q;
    if (oor_hit) begin
      oor_cnt_d = sat_inc16(oor_cnt_q);
    end
  end

  // The out-of-range strobe and the counter are both registered at the
  // request edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oor_err_q <= 1'b0;
      oor_cnt_q <= 16'd0;
    end else begin
      oor_err_q <= oor_hit;
      oor_cnt_q <= oor_cnt_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign oor_err = oor_err_q;
  assign oor_cnt = oor_cnt_q;

endmodule

// File: tb/tb_nlx_sram_slave.sv
// tb_nlx_sram_slave: three nlx_sram_slave instances share one request stream:
// DEPTH=1024/RD_LAT=1, DEPTH=1024/RD_LAT=3 and DEPTH=65536/RD_LAT=4.
// Expected read results are queued with their due cycle when a read is issued.
// They are popped when rvalid appears. Each cycle the bench checks rdata hold,
// oor_err and oor_cnt.
module tb_nlx_sram_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cs;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic [31:0] rd [3];
  logic        rv [3];
  logic        oe [3];
  logic [15:0] oc [3];

  always #5 clk = ~clk;

  nlx_sram_slave #(.DEPTH(1024), .RD_LAT(1)) u_l1 (
    .clk(clk), .rstn(rstn), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rd[0]), .rvalid(rv[0]), .oor_err(oe[0]), .oor_cnt(oc[0]));
  nlx_sram_slave #(.DEPTH(1024), .RD_LAT(3)) u_l3 (
    .clk(clk), .rstn(rstn), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rd[1]), .rvalid(rv[1]), .oor_err(oe[1]), .oor_cnt(oc[1]));
  nlx_sram_slave #(.DEPTH(65536), .RD_LAT(4)) u_full (
    .clk(clk), .rstn(rstn), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rd[2]), .rvalid(rv[2]), .oor_err(oe[2]), .oor_cnt(oc[2]));

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } sb_t;

  typedef struct {
    logic        cs;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_s;   // read result seen by the DEPTH=1024 instances
    logic [31:0] exp_f;   // read result seen by the DEPTH=65536 instance
  } vec_t;

  sb_t         sbq [3][$];
  int unsigned lat [3];
  logic [31:0] last [3];
  int unsigned cyc;
  int          n_cmp;
  int          n_bad;
  logic        exp_err_s;
  logic [15:0] cnt_s;

  task automatic chk(input string what, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h, expected %h", what, inst, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    sb_t h;
    for (int i = 0; i < 3; i++) begin
      chk("oor_err", i, {31'd0, oe[i]}, {31'd0, (i < 2) ? exp_err_s : 1'b0});
      chk("oor_cnt", i, {16'd0, oc[i]}, {16'd0, (i < 2) ? cnt_s : 16'd0});
      if (rv[i]) begin
        if (sbq[i].size() == 0) begin
          chk("spurious_rvalid", i, {31'd0, rv[i]}, 32'd0);
        end else begin
          h = sbq[i].pop_front();
          chk("rd_latency", i, cyc, h.due);
          chk("rdata", i, rd[i], h.data);
          last[i] = h.data;
        end
      end else begin
        chk("rdata_hold", i, rd[i], last[i]);
        if (sbq[i].size() != 0 && sbq[i][0].due <= cyc) begin
          chk("missing_rvalid", i, {31'd0, rv[i]}, 32'd1);
          void'(sbq[i].pop_front());
        end
      end
    end
  endtask

  // One bus cycle: drive at the negedge, model at the posedge, check at the next negedge.
  task automatic step(input logic c, input logic [3:0] w, input logic [15:0] a,
                      input logic [31:0] d, input logic [31:0] es, input logic [31:0] ef);
    sb_t e;
    cs = c; we = w; addr = a; wdata = d;
    @(posedge clk);
    cyc++;
    if (rstn) begin
      exp_err_s = c && (a >= 16'd1024);
      if (exp_err_s && cnt_s != 16'hFFFF) cnt_s = cnt_s + 16'd1;
      if (c && w == 4'd0) begin
        for (int i = 0; i < 3; i++) begin
          e.data = (i == 2) ? ef : es;
          e.due  = cyc + lat[i] - 1;
          sbq[i].push_back(e);
        end
      end
    end else begin
      exp_err_s = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'h0, 16'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Asynchronous reset between edges: outputs must clear at once.
  task automatic reset_mid();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdata", i, rd[i], 32'd0);
      chk("rst_rvalid", i, {31'd0, rv[i]}, 32'd0);
      chk("rst_oor_err", i, {31'd0, oe[i]}, 32'd0);
      chk("rst_oor_cnt", i, {16'd0, oc[i]}, 32'd0);
      sbq[i].delete();
      last[i] = 32'd0;
    end
    cnt_s = 16'd0;
    exp_err_s = 1'b0;
    @(negedge clk);
    idle(2);
    rstn = 1'b1;
  endtask

  vec_t tbl [25];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 16'h0000, 32'h0000_0A0A, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 4'hF, 16'h0010, 32'h1234_5678, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 4'h0, 16'h0010, 32'h0, 32'h1234_5678, 32'h1234_5678};
    tbl[3]  = '{1'b1, 4'hF, 16'h0005, 32'hAABB_CCDD, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 4'h5, 16'h0005, 32'h1122_3344, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 4'h0, 16'h0005, 32'h0, 32'hAA22_CC44, 32'hAA22_CC44};
    tbl[6]  = '{1'b1, 4'hF, 16'h0001, 32'h1, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 4'hF, 16'h0002, 32'h2, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 4'hF, 16'h0003, 32'h3, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 4'h0, 16'h0001, 32'h0, 32'h1, 32'h1};
    tbl[10] = '{1'b1, 4'h0, 16'h0002, 32'h0, 32'h2, 32'h2};
    tbl[11] = '{1'b1, 4'h0, 16'h0003, 32'h0, 32'h3, 32'h3};
    tbl[12] = '{1'b0, 4'hF, 16'h0005, 32'h0, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 4'hF, 16'h0400, 32'hFFFF_FFFF, 32'h0, 32'h0};
    tbl[14] = '{1'b1, 4'h0, 16'h0000, 32'h0, 32'h0000_0A0A, 32'h0000_0A0A};
    tbl[15] = '{1'b1, 4'hF, 16'hFFFF, 32'h0BAD_F00D, 32'h0, 32'h0};
    tbl[16] = '{1'b1, 4'h0, 16'hFFFF, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    tbl[17] = '{1'b1, 4'h0, 16'h0400, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    tbl[18] = '{1'b1, 4'hF, 16'h03FF, 32'h5A5A_5A5A, 32'h0, 32'h0};
    tbl[19] = '{1'b1, 4'h0, 16'h03FF, 32'h0, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    tbl[20] = '{1'b1, 4'h0, 16'h0005, 32'h0, 32'hAA22_CC44, 32'hAA22_CC44};
    tbl[21] = '{1'b1, 4'h2, 16'h03FF, 32'h0000_BB00, 32'h0, 32'h0};
    tbl[22] = '{1'b1, 4'h0, 16'h03FF, 32'h0, 32'h5A5A_BB5A, 32'h5A5A_BB5A};
    tbl[23] = '{1'b1, 4'hF, 16'h0401, 32'h0, 32'h0, 32'h0};
    tbl[24] = '{1'b1, 4'h0, 16'h0001, 32'h0, 32'h1, 32'h1};

    lat[0] = 1; lat[1] = 3; lat[2] = 4;
    n_cmp = 0; n_bad = 0; cyc = 0;
    cnt_s = 16'd0; exp_err_s = 1'b0;
    rstn = 1'b1; cs = 1'b0; we = 4'h0; addr = 16'h0; wdata = 32'h0;

    @(negedge clk);
    reset_mid();

    for (int k = 0; k < 25; k++) begin
      step(tbl[k].cs, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].exp_s, tbl[k].exp_f);
    end
    idle(5);

    // A read is in flight in the RD_LAT=4 instance when reset hits.
    step(1'b1, 4'h0, 16'h0001, 32'h0, 32'h1, 32'h1);
    idle(2);
    reset_mid();
    idle(5);
    step(1'b1, 4'h0, 16'h0003, 32'h0, 32'h3, 32'h3);
    step(1'b1, 4'h0, 16'h0010, 32'h0, 32'h1234_5678, 32'h1234_5678);
    step(1'b1, 4'h0, 16'h0005, 32'h0, 32'hAA22_CC44, 32'hAA22_CC44);
    idle(5);

    // Drive the out-of-range counter past saturation.
    for (int k = 0; k < 65537; k++) begin
      step(1'b1, 4'hF, 16'hFFFF, 32'h0, 32'h0, 32'h0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
